// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage feeding decode.
//
// Owns the PC and issues fetches on an SRAM-like instruction port with at
// most one request outstanding. Fetched words are presented to decode as a
// registered {valid, pc, inst, adel} bundle. A one-entry hold buffer absorbs
// a word that returns while decode is stalled. Later stages may redirect the
// PC (branch/jump/exception) or flush the presented instruction.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   stall_i                     decode cannot accept; id_* hold
//   flush_i                     kill id_* and the hold buffer
//   redirect_valid/redirect_pc  new fetch target
//   inst_req/inst_addr          fetch request and address (= pc)
//   inst_addr_ok                request accepted this cycle
//   inst_data_ok/inst_rdata     read data return
//   id_valid/id_pc/id_inst      instruction presented to decode
//   id_adel                     presented pc is misaligned; id_inst = 0
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;   // pc of the outstanding request
    logic        cancel_q, cancel_d;       // outstanding data must be dropped
    logic        adel_done_q, adel_done_d; // misaligned pc already reported
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_adel_q, id_adel_d;

    logic misaligned;
    logic id_free;

    assign misaligned = (pc_q[1:0] != 2'b00);
    assign id_free    = !id_valid_q || !stall_i;

    // A redirect drops the request so the address never changes under a
    // pending request; the new target is issued from the next cycle.
    assign inst_req  = !rst && (state_q == S_REQ) && !misaligned && !redirect_valid;
    assign inst_addr = pc_q;

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_adel  = id_adel_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        cancel_d    = cancel_q;
        adel_done_d = adel_done_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        // Hold under stall, otherwise bubble unless something loads below.
        id_valid_d  = id_valid_q && stall_i;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_adel_d   = id_adel_q;

        if (redirect_valid) begin
            adel_done_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (misaligned) begin
                    // Report the bad pc once, then idle until redirected.
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (!adel_done_q && id_free && !flush_i) begin
                        id_valid_d  = 1'b1;
                        id_pc_d     = pc_q;
                        id_inst_d   = 32'h0;
                        id_adel_d   = 1'b1;
                        adel_done_d = 1'b1;
                    end
                end else if (inst_addr_ok) begin
                    // Accepted even alongside a redirect: the slave owns it
                    // now, so its data is marked for dropping.
                    fetch_pc_d = pc_q;
                    state_d    = S_WAIT;
                    cancel_d   = redirect_valid;
                    pc_d       = redirect_valid ? redirect_pc : pc_q + 32'd4;
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end

            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d  = S_REQ;
                    cancel_d = 1'b0;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
                    // Flush kills the word arriving on the same edge too.
                    if (!cancel_q && !redirect_valid && !flush_i) begin
                        if (id_free) begin
                            id_valid_d = 1'b1;
                            id_pc_d    = fetch_pc_q;
                            id_inst_d  = inst_rdata;
                            id_adel_d  = 1'b0;
                        end else begin
                            buf_pc_d   = fetch_pc_q;
                            buf_inst_d = inst_rdata;
                            state_d    = S_HOLD;
                        end
                    end
                end else if (redirect_valid) begin
                    cancel_d = 1'b1;
                    pc_d     = redirect_pc;
                end
            end

            S_HOLD: begin
                if (redirect_valid || flush_i) begin
                    state_d = S_REQ;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
                end else if (!stall_i) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = buf_pc_q;
                    id_inst_d  = buf_inst_q;
                    id_adel_d  = 1'b0;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        if (flush_i) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= 32'h0;
            cancel_q    <= 1'b0;
            adel_done_q <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_inst_q  <= 32'h0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'h0;
            id_inst_q   <= 32'h0;
            id_adel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            cancel_q    <= cancel_d;
            adel_done_q <= adel_done_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_adel_q   <= id_adel_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A table of per-cycle vectors covers the zero-wait stream and a stall that
// forces the hold buffer; hand sequences cover redirect, misaligned pc, flush
// and mid-operation reset; a random phase drives random stall and memory
// latency and checks that fetched words reach decode in order.
// ----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] KEY    = 32'h1111_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_adel        (id_adel)
    );

    int total = 0;
    int bad   = 0;

    // Memory: auto mode answers requests itself; manual mode copies m_*.
    bit          mem_auto = 1'b0;
    bit          mem_rand = 1'b0;
    logic        m_aok = 1'b0;
    logic        m_dok = 1'b0;
    logic [31:0] m_rd  = 32'h0;
    bit          pending = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          pdelay = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) pending = 1'b0;
            if (mem_auto) begin
                inst_data_ok = 1'b0;
                inst_addr_ok = 1'b0;
                if (pending) begin
                    if (pdelay == 0) begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = paddr ^ KEY;
                        pending      = 1'b0;
                    end else begin
                        pdelay = pdelay - 1;
                    end
                end
                if (inst_req && !pending)
                    inst_addr_ok = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            end else begin
                inst_addr_ok = m_aok;
                inst_data_ok = m_dok;
                inst_rdata   = m_rd;
            end
            @(negedge clk);
            if (mem_auto && inst_req && inst_addr_ok) begin
                pending = 1'b1;
                paddr   = inst_addr;
                pdelay  = mem_rand ? int'($urandom_range(0, 3)) : 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, return at the negedge.
    task automatic apply(input logic st, input logic fl, input logic rv,
                         input logic [31:0] rpc, input logic aok, input logic dok,
                         input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        stall_i        = st;
        flush_i        = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        m_aok          = aok;
        m_dok          = dok;
        m_rd           = rd;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit check);
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall_i = 1'b0; flush_i = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        m_aok = 1'b0; m_dok = 1'b0; m_rd = 32'h0;
        @(posedge clk);
        @(negedge clk);
        if (check) begin
            chk("rst_req", {31'h0, inst_req}, 32'h0);
            chk("rst_valid", {31'h0, id_valid}, 32'h0);
            chk("rst_pc", id_pc, 32'h0);
            chk("rst_inst", id_inst, 32'h0);
            chk("rst_adel", {31'h0, id_adel}, 32'h0);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[10];

    logic [31:0] q[$];
    logic [31:0] next_addr;
    logic [31:0] hold_pc;
    logic [31:0] exp_pc;
    bit          prev_hold;
    bit          st;
    int          delivered;

    initial begin
        // Zero-wait memory; stall for 4 cycles while BFC00004 returns.
        vecs[0] = '{1'b0, 1'b1, RST_PC,         1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, RST_PC + 32'd4, 1'b1, RST_PC};
        vecs[3] = '{1'b1, 1'b0, 32'h0,          1'b1, RST_PC};
        vecs[4] = '{1'b1, 1'b0, 32'h0,          1'b1, RST_PC};
        vecs[5] = '{1'b1, 1'b0, 32'h0,          1'b1, RST_PC};
        vecs[6] = '{1'b0, 1'b0, 32'h0,          1'b1, RST_PC};
        vecs[7] = '{1'b0, 1'b1, RST_PC + 32'd8, 1'b1, RST_PC + 32'd4};
        vecs[8] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0};
        vecs[9] = '{1'b0, 1'b1, RST_PC + 32'd12, 1'b1, RST_PC + 32'd8};

        do_reset(1'b1);
        mem_auto = 1'b1;
        mem_rand = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].stall, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk($sformatf("vec%0d_req", i), {31'h0, inst_req}, {31'h0, vecs[i].req});
            if (vecs[i].req) chk($sformatf("vec%0d_addr", i), inst_addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].valid});
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_pc", i), id_pc, vecs[i].pc);
                chk($sformatf("vec%0d_inst", i), id_inst, vecs[i].pc ^ KEY);
                chk($sformatf("vec%0d_adel", i), {31'h0, id_adel}, 32'h0);
            end
        end

        // Redirect while waiting; data returns 3 cycles later and is dropped.
        mem_auto = 1'b0;
        do_reset(1'b0);
        apply(0, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("rw_req0", {31'h0, inst_req}, 32'h1);
        apply(0, 0, 1, 32'h8000_1000, 0, 0, 32'h0);
        chk("rw_req_redir", {31'h0, inst_req}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
            chk("rw_wait_req", {31'h0, inst_req}, 32'h0);
        end
        apply(0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        chk("rw_data_valid", {31'h0, id_valid}, 32'h0);
        apply(0, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("rw_new_req", {31'h0, inst_req}, 32'h1);
        chk("rw_new_addr", inst_addr, 32'h8000_1000);
        chk("rw_no_stale", {31'h0, id_valid}, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 1, 32'h8000_1000 ^ KEY);
        chk("rw_no_stale2", {31'h0, id_valid}, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("rw_valid", {31'h0, id_valid}, 32'h1);
        chk("rw_pc", id_pc, 32'h8000_1000);
        chk("rw_inst", id_inst, 32'h8000_1000 ^ KEY);

        // Redirect together with data_ok.
        do_reset(1'b0);
        apply(0, 0, 0, 32'h0, 1, 0, 32'h0);
        apply(0, 0, 1, 32'h8000_3000, 0, 1, 32'hDEAD_BEEF);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("rd_req", {31'h0, inst_req}, 32'h1);
        chk("rd_addr", inst_addr, 32'h8000_3000);
        chk("rd_valid", {31'h0, id_valid}, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("rd_valid2", {31'h0, id_valid}, 32'h0);

        // Redirect together with addr_ok.
        do_reset(1'b0);
        apply(0, 0, 1, 32'h8000_4000, 1, 0, 32'h0);
        chk("ra_req", {31'h0, inst_req}, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        chk("ra_wait_req", {31'h0, inst_req}, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("ra_req2", {31'h0, inst_req}, 32'h1);
        chk("ra_addr", inst_addr, 32'h8000_4000);
        chk("ra_valid", {31'h0, id_valid}, 32'h0);

        // Misaligned redirect target.
        do_reset(1'b0);
        apply(0, 0, 1, 32'h8000_1002, 0, 0, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("mis_req", {31'h0, inst_req}, 32'h0);
        apply(1, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("mis_valid", {31'h0, id_valid}, 32'h1);
        chk("mis_adel", {31'h0, id_adel}, 32'h1);
        chk("mis_pc", id_pc, 32'h8000_1002);
        chk("mis_inst", id_inst, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("mis_hold", {31'h0, id_valid}, 32'h1);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("mis_once", {31'h0, id_valid}, 32'h0);
        chk("mis_req2", {31'h0, inst_req}, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("mis_idle", {31'h0, inst_req}, 32'h0);
        apply(0, 0, 1, 32'h8000_2000, 0, 0, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("mis_resume_req", {31'h0, inst_req}, 32'h1);
        chk("mis_resume_addr", inst_addr, 32'h8000_2000);

        // Flush overrides stall.
        do_reset(1'b0);
        apply(0, 0, 0, 32'h0, 1, 0, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 1, RST_PC ^ KEY);
        apply(1, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("fl_valid", {31'h0, id_valid}, 32'h1);
        apply(1, 1, 0, 32'h0, 0, 0, 32'h0);
        apply(1, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("fl_killed", {31'h0, id_valid}, 32'h0);
        chk("fl_addr", inst_addr, RST_PC + 32'd4);

        // Reset while waiting; late data_ok after reset is ignored.
        do_reset(1'b0);
        apply(0, 0, 0, 32'h0, 1, 0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1; m_aok = 1'b0; m_dok = 1'b0;
        @(negedge clk);
        chk("mr_req_in_rst", {31'h0, inst_req}, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        chk("mr_req", {31'h0, inst_req}, 32'h1);
        chk("mr_addr", inst_addr, RST_PC);
        chk("mr_pc", id_pc, 32'h0);
        apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("mr_valid", {31'h0, id_valid}, 32'h0);
        chk("mr_addr2", inst_addr, RST_PC);

        // Random stall and memory latency: words reach decode in fetch order.
        do_reset(1'b0);
        mem_auto  = 1'b1;
        mem_rand  = 1'b1;
        q.delete();
        next_addr = RST_PC;
        prev_hold = 1'b0;
        hold_pc   = 32'h0;
        delivered = 0;
        for (int c = 0; c < 800; c++) begin
            st = ($urandom_range(0, 2) == 0);
            apply(st, 0, 0, 32'h0, 0, 0, 32'h0);
            if (inst_req) begin
                chk("rnd_addr", inst_addr, next_addr);
                if (inst_addr_ok) begin
                    q.push_back(next_addr);
                    next_addr = next_addr + 32'd4;
                end
            end
            if (prev_hold) begin
                chk("rnd_hold_valid", {31'h0, id_valid}, 32'h1);
                chk("rnd_hold_pc", id_pc, hold_pc);
            end
            if (id_valid && !st) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_order: got pc %h want none outstanding", id_pc);
                end else begin
                    exp_pc = q.pop_front();
                    chk("rnd_pc", id_pc, exp_pc);
                    chk("rnd_inst", id_inst, exp_pc ^ KEY);
                    chk("rnd_adel", {31'h0, id_adel}, 32'h0);
                    delivered++;
                end
            end
            prev_hold = id_valid && st;
            hold_pc   = id_pc;
        end
        chk("rnd_progress", {31'h0, delivered >= 80}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
